// File: rtl/dlx_pkg.sv
// dlx_pkg: opcode map, FSM states and tracker slot layout shared by the DLX hazard controller.
package dlx_pkg;
    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_BEQZ    = 6'h04;
    localparam logic [5:0] OP_BNEZ    = 6'h05;
    localparam logic [5:0] OP_ALUI_LO = 6'h08;
    localparam logic [5:0] OP_ALUI_HI = 6'h0E;
    localparam logic [5:0] OP_LHI     = 6'h0F;
    localparam logic [5:0] OP_SETI_LO = 6'h18;
    localparam logic [5:0] OP_SETI_HI = 6'h1D;
    localparam logic [5:0] OP_LD_LO   = 6'h20;
    localparam logic [5:0] OP_LD_HI   = 6'h27;
    localparam logic [5:0] OP_ST_LO   = 6'h28;
    localparam logic [5:0] OP_ST_HI   = 6'h2F;
    localparam logic [5:0] OP_HALT    = 6'h3F;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             is_ld;
        logic             is_br;
        logic [REG_W-1:0] dreg;
    } slot_t;

    function automatic logic in_range(input logic [5:0] v, input logic [5:0] lo, input logic [5:0] hi);
        return v >= lo && v <= hi;
    endfunction
endpackage

// File: rtl/dlx_instr_class.sv
// dlx_instr_class: decodes an opcode into the register-usage classes the interlock needs.
module dlx_instr_class
    import dlx_pkg::*;
(
    input  logic [0:5] op,
    input  logic [0:5] fc,
    output logic       writes_rd,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       is_ld,
    output logic       is_br,
    output logic       is_halt
);
    logic [5:0] o;
    logic       unused_fc;

    // The function code never changes register usage of an R-type instruction.
    assign unused_fc = ^fc;
    assign o         = op;
    assign is_ld     = in_range(o, OP_LD_LO, OP_LD_HI);
    assign is_br     = o == OP_BEQZ || o == OP_BNEZ;
    assign is_halt   = o == OP_HALT;
    assign writes_rd = o == OP_RTYPE || in_range(o, OP_ALUI_LO, OP_LHI)
                     || in_range(o, OP_SETI_LO, OP_SETI_HI) || is_ld;
    assign uses_rs1  = o == OP_RTYPE || is_br || in_range(o, OP_ALUI_LO, OP_ALUI_HI)
                     || in_range(o, OP_SETI_LO, OP_SETI_HI) || in_range(o, OP_LD_LO, OP_ST_HI);
    assign uses_rs2  = o == OP_RTYPE || in_range(o, OP_ST_LO, OP_ST_HI);
endmodule

// File: rtl/dlx_hazard_ctrl.sv
// dlx_hazard_ctrl: DLX interlock, branch flush and HALT drain sequencer; state moves on negedge clock.
// Optional build macro DLX_FORWARD_EN: assume EX/MEM forwarding, interlock only on load-use.
module dlx_hazard_ctrl
    import dlx_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic [0:5]             id_op,
    input  logic [0:5]             id_fc,
    input  logic [0:4]             id_rs1,
    input  logic [0:4]             id_rs2,
    input  logic [0:4]             id_rd,
    input  logic                   ex_cond,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   pc_sel_br,
    output logic                   halted,
    output logic [0:STALL_CNT_W-1] stall_cycles
);
    logic       writes_rd, uses_rs1, uses_rs2, is_ld, is_br, is_halt;
    logic       src1, src2, raw, running, flush, stall;
    logic       unused_bits;
    logic [2:0] drain_cnt;
    slot_t      id_slot, ex_slot, mem_slot;
    state_t     state;

    dlx_instr_class u_class (
        .op        (id_op),
        .fc        (id_fc),
        .writes_rd (writes_rd),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .is_ld     (is_ld),
        .is_br     (is_br),
        .is_halt   (is_halt)
    );

    function automatic logic hit(input slot_t s, input logic [REG_W-1:0] r);
        return s.valid && s.wr && s.dreg == r;
    endfunction

    assign id_slot = '{valid: id_valid, wr: writes_rd && id_rd != '0, is_ld: is_ld, is_br: is_br, dreg: id_rd};
    assign src1    = uses_rs1 && id_rs1 != '0;
    assign src2    = uses_rs2 && id_rs2 != '0;
`ifdef DLX_FORWARD_EN
    assign raw = ex_slot.is_ld && ((src1 && hit(ex_slot, id_rs1)) || (src2 && hit(ex_slot, id_rs2)));
`else
    assign raw = (src1 && (hit(ex_slot, id_rs1) || hit(mem_slot, id_rs1)))
              || (src2 && (hit(ex_slot, id_rs2) || hit(mem_slot, id_rs2)));
`endif
    // The WB slot is absent on purpose: the regfile writes before it reads.
    assign unused_bits = ^mem_slot;
    assign running     = state == ST_RUN;
    assign flush       = running && ex_slot.valid && ex_slot.is_br && ex_cond;
    assign stall       = running && id_valid && raw && !flush;
    assign pc_write    = running && !stall;
    assign ifid_write  = running && !stall;
    assign ifid_flush  = flush;
    assign idex_bubble = !running || stall || flush;
    assign pc_sel_br   = flush;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_slot      <= '0;
            mem_slot     <= '0;
            state        <= ST_RUN;
            drain_cnt    <= '0;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            mem_slot <= ex_slot;
            ex_slot  <= idex_bubble ? '0 : id_slot;
            if (stall && ~&stall_cycles)
                stall_cycles <= stall_cycles + 1'b1;
            case (state)
                ST_RUN: if (id_valid && is_halt && !stall && !flush) begin
                    state     <= ST_DRAIN;
                    drain_cnt <= 3'(DRAIN_CYCLES - 1);
                end
                ST_DRAIN: if (drain_cnt == '0) begin
                    state  <= ST_HALTED;
                    halted <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt - 1'b1;
                end
                default: state <= ST_HALTED;
            endcase
        end
    end
endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// tb_dlx_hazard_ctrl: randomized and directed checks of the DLX hazard controller against a pipeline model.
module tb_dlx_hazard_ctrl;
    localparam int CW = 4;
    localparam int DC = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock = 1'b0, reset_n = 1'b0, id_valid = 1'b0, ex_cond = 1'b0;
    logic [0:5]    id_op = '0, id_fc = '0;
    logic [0:4]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel_br, halted;
    logic [0:CW-1] stall_cycles;

    dlx_hazard_ctrl #(.DRAIN_CYCLES(DC), .STALL_CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_op(id_op), .id_fc(id_fc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_cond(ex_cond),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pc_sel_br(pc_sel_br), .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: in-flight instructions as plain records; dest 0 means "writes nothing".
    typedef struct {bit v; int dest; bit ld; bit br;} ent_t;
    ent_t m_ex, m_mem;
    int   negs, t_h, m_cnt;
    bit   running, e_stall, e_flush, e_halted, last_hold;
    logic [31:0] exp_vec;

    function automatic bit f_wr(input int op);
        return op == 0 || (op >= 8 && op <= 15) || (op >= 24 && op <= 29) || (op >= 32 && op <= 39);
    endfunction
    function automatic bit f_rs1(input int op);
        return op == 0 || op == 4 || op == 5 || (op >= 8 && op <= 14) || (op >= 24 && op <= 29) || (op >= 32 && op <= 47);
    endfunction
    function automatic bit f_rs2(input int op);
        return op == 0 || (op >= 40 && op <= 47);
    endfunction
    function automatic bit dep(input int s);
        if (s == 0) return 0;
`ifdef DLX_FORWARD_EN
        return m_ex.v && m_ex.ld && m_ex.dest == s;
`else
        return (m_ex.v && m_ex.dest == s) || (m_mem.v && m_mem.dest == s);
`endif
    endfunction

    function automatic logic [31:0] out_vec();
        return {20'd0, halted, pc_sel_br, idex_bubble, ifid_flush, ifid_write, pc_write, 2'b00, stall_cycles};
    endfunction

    task automatic model_reset();
        m_ex = '{0, 0, 0, 0};
        m_mem = '{0, 0, 0, 0};
        negs = 0; t_h = -1; m_cnt = 0;
    endtask

    task automatic evaluate();
        int op, s1, s2;
        bit hz;
        op = int'(id_op);
        s1 = (id_valid && f_rs1(op)) ? int'(id_rs1) : 0;
        s2 = (id_valid && f_rs2(op)) ? int'(id_rs2) : 0;
        hz = dep(s1) || dep(s2);
        running  = t_h < 0;
        e_halted = t_h >= 0 && negs >= t_h + DC;
        e_flush  = running && m_ex.v && m_ex.br && ex_cond;
        e_stall  = running && hz && !e_flush;
        exp_vec  = {20'd0, e_halted, e_flush, !running || e_stall || e_flush, e_flush,
                    running && !e_stall, running && !e_stall, 2'b00, 4'(m_cnt)};
    endtask

    task automatic advance();
        int op;
        op = int'(id_op);
        if (running && id_valid && op == 63 && !e_stall && !e_flush) t_h = negs + 1;
        negs++;
        if (e_stall && m_cnt < CMAX) m_cnt++;
        m_mem = m_ex;
        if (!running || e_stall || e_flush || !id_valid) m_ex = '{0, 0, 0, 0};
        else m_ex = '{1, f_wr(op) ? int'(id_rd) : 0, op >= 32 && op <= 39, op == 4 || op == 5};
    endtask

    // Called at a posedge with ID inputs already applied; returns at the next posedge.
    task automatic run_cycle();
        #1;
        evaluate();
        check("outputs", out_vec(), exp_vec);
        last_hold = !running || e_stall;
        @(negedge clock);
        advance();
        @(posedge clock);
    endtask

    task automatic set_id(input bit v, input int op, input int rs1, input int rs2, input int rd);
        id_valid = v; id_op = 6'(op); id_fc = 6'($urandom_range(0, 63));
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
    endtask

    task automatic issue(input int op, input int rs1, input int rs2, input int rd);
        int n;
        set_id(1, op, rs1, rs2, rd);
        ex_cond = 1'b0;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (last_hold && n < 8);
        if (last_hold) check("issue_timeout", 32'(n), 32'd0);
        id_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1 check("reset", out_vec(), {20'd0, 6'b000011, 6'd0});
        model_reset();
        @(negedge clock);
        @(posedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int ops[13] = '{0, 0, 4, 5, 8, 15, 24, 32, 35, 40, 43, 2, 48};
        int op;
        model_reset();
        last_hold = 0;
        repeat (2) @(posedge clock);
        do_reset();

        // RAW on an ALU result, then load-use.
        issue(0, 1, 2, 3);
        issue(0, 3, 5, 4);
`ifdef DLX_FORWARD_EN
        check("alu_raw_stalls", 32'(stall_cycles), 32'd0);
`else
        check("alu_raw_stalls", 32'(stall_cycles), 32'd2);
`endif
        do_reset();
        issue(35, 1, 0, 3);
        issue(8, 3, 0, 4);
`ifdef DLX_FORWARD_EN
        check("load_use_stalls", 32'(stall_cycles), 32'd1);
`else
        check("load_use_stalls", 32'(stall_cycles), 32'd2);
`endif
        // r0 is never a dependency.
        do_reset();
        issue(0, 1, 2, 0);
        issue(0, 0, 0, 5);
        check("r0_no_stall", 32'(stall_cycles), 32'd0);

        // Taken branch squashes a HALT in ID, then a real HALT drains.
        issue(4, 0, 0, 0);
        set_id(1, 63, 0, 0, 0);
        ex_cond = 1'b1;
        run_cycle();
        check("branch_flush", 32'(last_hold), 32'd0);
        ex_cond = 1'b0;
        id_valid = 1'b0;
        repeat (5) run_cycle();
        check("halt_squashed", 32'(halted), 32'd0);
        issue(63, 0, 0, 0);
        repeat (DC - 1) run_cycle();
        check("not_yet_halted", 32'(halted), 32'd0);
        run_cycle();
        check("halted", 32'(halted), 32'd1);
        repeat (2) run_cycle();
        do_reset();

        // Reset mid-stall and mid-drain.
        issue(35, 1, 0, 2);
        set_id(1, 0, 2, 2, 3);
        run_cycle();
        do_reset();
        issue(63, 0, 0, 0);
        run_cycle();
        do_reset();

        // Saturate the stall counter.
        repeat (20) begin
            issue(35, 2, 0, 1);
            issue(0, 1, 1, 2);
        end
        check("stall_saturate", 32'(stall_cycles), CMAX);
        do_reset();

        // Random instruction stream; ID holds while the controller blocks it.
        for (int i = 0; i < 1500; i++) begin
            if (!last_hold) begin
                op = ($urandom_range(0, 59) == 0) ? 63 : ops[$urandom_range(0, 12)];
                set_id(!e_flush && $urandom_range(0, 99) < 85, op, $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            end
            ex_cond = 1'($urandom_range(0, 1));
            run_cycle();
            if ((t_h >= 0 && negs >= t_h + DC + 3) || $urandom_range(0, 199) == 0) begin
                do_reset();
                last_hold = 0;
                e_flush = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
